// File: rtl/wshb_arb_pkg.sv
// rtl/wshb_arb_pkg.sv - shared state/owner types and bus widths for the Wishbone arbiter
package wshb_arb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 16;
    localparam int SEL_W = DAT_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN0   = 2'd1,
        OWN1   = 2'd2,
        SWITCH = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } owner_t;

endpackage

// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - Wishbone bus bundle with master and slave views
interface wshb_if;
    import wshb_arb_pkg::*;

    logic             cyc;
    logic             stb;
    logic [ADR_W-1:0] adr;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [2:0]       cti;
    logic [1:0]       bte;
    logic [DAT_W-1:0] dat_ms;
    logic [DAT_W-1:0] dat_sm;
    logic             ack;

    modport master (
        output cyc, stb, adr, we, sel, cti, bte, dat_ms,
        input  ack, dat_sm
    );

    modport slave (
        input  cyc, stb, adr, we, sel, cti, bte, dat_ms,
        output ack, dat_sm
    );

endinterface

// File: rtl/wshb_arbiter.sv
// rtl/wshb_arbiter.sv - two-master Wishbone arbiter with preemption; WSHB_ARB_RR_EN selects round-robin
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int MAX_ACKS = 64
)
(
    input  logic       clk,
    input  logic       rst,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] grant
);

    localparam int               CNT_W   = (MAX_ACKS > 1) ? $clog2(MAX_ACKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ACKS - 1);

    arb_state_t       state, state_next;
    owner_t           last, last_next;
    logic [CNT_W-1:0] ack_cnt, ack_cnt_next;

    logic cyc0, cyc1;
    logic owning, ack_fwd, owner_req, other_req, preempt_ok, at_limit;

    assign cyc0      = wshb_ifs0.cyc;
    assign cyc1      = wshb_ifs1.cyc;
    assign owning    = (state == OWN0) || (state == OWN1);
    assign ack_fwd   = owning && wshb_ifm.ack;
    assign owner_req = (state == OWN0) ? cyc0 : cyc1;
    assign other_req = (state == OWN0) ? cyc1 : cyc0;
    assign at_limit  = (ack_cnt == CNT_MAX);
`ifdef WSHB_ARB_RR_EN
    assign preempt_ok = owning;
`else
    assign preempt_ok = (state == OWN1);
`endif

    // state, last owner and ack counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= PORT1;
            ack_cnt <= '0;
        end else begin
            state   <= state_next;
            last    <= last_next;
            ack_cnt <= ack_cnt_next;
        end
    end

    // next owner: tie-break from idle, release, preemption through a dead cycle
    always_comb begin
        state_next   = state;
        last_next    = last;
        ack_cnt_next = '0;
        case (state)
            IDLE: begin
                if (cyc0 && cyc1) begin
`ifdef WSHB_ARB_RR_EN
                    state_next = (last == PORT0) ? OWN1 : OWN0;
                    last_next  = (last == PORT0) ? PORT1 : PORT0;
`else
                    state_next = OWN0;
                    last_next  = PORT0;
`endif
                end else if (cyc0) begin
                    state_next = OWN0;
                    last_next  = PORT0;
                end else if (cyc1) begin
                    state_next = OWN1;
                    last_next  = PORT1;
                end
            end
            OWN0, OWN1: begin
                if (other_req) begin
                    ack_cnt_next = (ack_fwd && !at_limit) ? ack_cnt + 1'b1 : ack_cnt;
                end
                if (!owner_req) begin
                    state_next = IDLE;
                end else if (preempt_ok && ack_fwd && other_req && at_limit) begin
                    state_next = SWITCH;
                end
            end
            SWITCH: begin
                // last still names the preempted owner here
                if ((last == PORT0) ? cyc1 : cyc0) begin
                    state_next = (last == PORT0) ? OWN1 : OWN0;
                    last_next  = (last == PORT0) ? PORT1 : PORT0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // forward the registered owner's request; nothing leaves while unowned
    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.adr    = '0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.sel    = '0;
        wshb_ifm.cti    = '0;
        wshb_ifm.bte    = '0;
        wshb_ifm.dat_ms = '0;
        if (state == OWN0) begin
            wshb_ifm.cyc    = wshb_ifs0.cyc;
            wshb_ifm.stb    = wshb_ifs0.stb;
            wshb_ifm.adr    = wshb_ifs0.adr;
            wshb_ifm.we     = wshb_ifs0.we;
            wshb_ifm.sel    = wshb_ifs0.sel;
            wshb_ifm.cti    = wshb_ifs0.cti;
            wshb_ifm.bte    = wshb_ifs0.bte;
            wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
        end else if (state == OWN1) begin
            wshb_ifm.cyc    = wshb_ifs1.cyc;
            wshb_ifm.stb    = wshb_ifs1.stb;
            wshb_ifm.adr    = wshb_ifs1.adr;
            wshb_ifm.we     = wshb_ifs1.we;
            wshb_ifm.sel    = wshb_ifs1.sel;
            wshb_ifm.cti    = wshb_ifs1.cti;
            wshb_ifm.bte    = wshb_ifs1.bte;
            wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
        end
    end

    assign wshb_ifs0.ack    = wshb_ifm.ack && (state == OWN0);
    assign wshb_ifs1.ack    = wshb_ifm.ack && (state == OWN1);
    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
    assign grant            = {state == OWN1, state == OWN0};

endmodule

// File: tb/tb_wshb_arbiter.sv
// tb/tb_wshb_arbiter.sv - directed and randomized checks of wshb_arbiter against a bus-ownership model
module tb_wshb_arbiter;
    import wshb_arb_pkg::*;

    localparam int MAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;

    wshb_if if0();
    wshb_if if1();
    wshb_if ifm();

    wshb_arbiter #(.MAX_ACKS(MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .wshb_ifs0 (if0),
        .wshb_ifs1 (if1),
        .wshb_ifm  (ifm),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: who owns the bus, who owned it last, dead-cycle flag, acks taken while the other waited
    int m_owner;
    int m_last;
    int m_prev;
    int m_wait;
    bit m_gap;

    logic             t_cyc [2];
    logic [ADR_W-1:0] t_adr [2];
    logic             t_we  [2];
    logic [SEL_W-1:0] t_sel [2];
    logic [2:0]       t_cti [2];
    logic [1:0]       t_bte [2];
    logic [DAT_W-1:0] t_dat [2];

    logic [1:0] obs_grant;
    logic       obs_ack0, obs_ack1;
    int         acks0, acks1;
    bit         rc0, rc1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit preemptible(input int o);
`ifdef WSHB_ARB_RR_EN
        return 1'b1;
`else
        return (o == 1);
`endif
    endfunction

    task automatic model(input bit c0, input bit c1, input bit a, input bit r);
        bit c [2];
        int o, oth, pick;
        c[0] = c0;
        c[1] = c1;
        if (r) begin
            m_owner = -1; m_gap = 0; m_last = 1; m_wait = 0;
        end else if (m_gap) begin
            m_gap = 0;
            oth = 1 - m_prev;
            if (c[oth]) begin
                m_owner = oth; m_last = oth; m_wait = 0;
            end else begin
                m_owner = -1;
            end
        end else if (m_owner < 0) begin
            pick = -1;
            if (c0 && c1) begin
`ifdef WSHB_ARB_RR_EN
                pick = 1 - m_last;
`else
                pick = 0;
`endif
            end else if (c0) pick = 0;
            else if (c1) pick = 1;
            if (pick >= 0) begin
                m_owner = pick; m_last = pick; m_wait = 0;
            end
        end else begin
            o   = m_owner;
            oth = 1 - o;
            if (!c[o]) begin
                m_owner = -1;
            end else if (!c[oth]) begin
                m_wait = 0;
            end else if (a) begin
                m_wait++;
                if (m_wait == MAX && preemptible(o)) begin
                    m_gap = 1; m_prev = o; m_owner = -1;
                end
            end
        end
    endtask

    // one bus cycle: drive after the falling edge, check mid-cycle, then advance the model
    task automatic step(input bit c0, input bit c1, input bit a, input bit r);
        logic [DAT_W-1:0] sm;
        logic [63:0]      exp_f;
        int               o;
        @(negedge clk);
        rst = r;
        t_cyc[0] = c0;
        t_cyc[1] = c1;
        for (int p = 0; p < 2; p++) begin
            t_adr[p] = ADR_W'($urandom);
            t_we[p]  = 1'($urandom);
            t_sel[p] = SEL_W'($urandom);
            t_cti[p] = 3'($urandom);
            t_bte[p] = 2'($urandom);
            t_dat[p] = DAT_W'($urandom);
        end
        if0.cyc = t_cyc[0]; if0.stb = t_cyc[0]; if0.adr = t_adr[0]; if0.we = t_we[0];
        if0.sel = t_sel[0]; if0.cti = t_cti[0]; if0.bte = t_bte[0]; if0.dat_ms = t_dat[0];
        if1.cyc = t_cyc[1]; if1.stb = t_cyc[1]; if1.adr = t_adr[1]; if1.we = t_we[1];
        if1.sel = t_sel[1]; if1.cti = t_cti[1]; if1.bte = t_bte[1]; if1.dat_ms = t_dat[1];
        sm = DAT_W'($urandom);
        ifm.ack    = a;
        ifm.dat_sm = sm;
        #1;
        o = m_owner;
        obs_grant = grant;
        obs_ack0  = if0.ack;
        obs_ack1  = if1.ack;
        acks0 += int'(obs_ack0);
        acks1 += int'(obs_ack1);
        chk("grant", 64'(grant), (o == 0) ? 64'd1 : (o == 1) ? 64'd2 : 64'd0);
        exp_f = 64'd0;
        if (o >= 0)
            exp_f = 64'({t_cyc[o], t_cyc[o], t_adr[o], t_we[o], t_sel[o], t_cti[o], t_bte[o], t_dat[o]});
        chk("forward", 64'({ifm.cyc, ifm.stb, ifm.adr, ifm.we, ifm.sel, ifm.cti, ifm.bte, ifm.dat_ms}), exp_f);
        chk("ack_route", 64'({if1.ack, if0.ack}), 64'({(o == 1) && a, (o == 0) && a}));
        chk("dat_sm", 64'({if1.dat_sm, if0.dat_sm}), 64'({sm, sm}));
        @(posedge clk);
        model(c0, c1, a, r);
    endtask

    initial begin
        rst = 1'b1;
        if0.cyc = 0; if0.stb = 0; if0.adr = '0; if0.we = 0; if0.sel = '0; if0.cti = '0; if0.bte = '0; if0.dat_ms = '0;
        if1.cyc = 0; if1.stb = 0; if1.adr = '0; if1.we = 0; if1.sel = '0; if1.cti = '0; if1.bte = '0; if1.dat_ms = '0;
        ifm.ack = 0; ifm.dat_sm = '0;
        m_owner = -1; m_last = 1; m_prev = 0; m_wait = 0; m_gap = 0;
        acks0 = 0; acks1 = 0;
        repeat (2) @(posedge clk);

        // reset state
        step(0, 0, 0, 1);
        #1;
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_ack_cnt", 64'(dut.ack_cnt), 64'd0);
        chk("reset_last", 64'(dut.last), 64'd1);
        chk("reset_fwd_cyc", 64'({ifm.cyc, ifm.stb}), 64'd0);

        // port 0 alone: one cycle grant latency, ten reads to port 0 only
        acks0 = 0; acks1 = 0;
        step(1, 0, 1, 0);
        chk("s1_latency", 64'(obs_grant), 64'd0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0);
            chk("s1_grant", 64'(obs_grant), 64'd1);
        end
        chk("s1_acks0", 64'(acks0), 64'd10);
        chk("s1_acks1", 64'(acks1), 64'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // port 0 streaming, port 1 joins at ack 5
        step(1, 0, 1, 0);
        acks0 = 0;
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
`ifdef WSHB_ARB_RR_EN
        acks0 = 0;
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        chk("s2_acks_before_preempt", 64'(acks0), 64'd4);
        step(1, 1, 1, 0);
        chk("s2_dead_grant", 64'(obs_grant), 64'd0);
        chk("s2_dead_acks", 64'({obs_ack1, obs_ack0}), 64'd0);
        step(1, 1, 1, 0);
        chk("s2_switch_grant", 64'(obs_grant), 64'd2);
        chk("s2_switch_ack1", 64'(obs_ack1), 64'd1);
`else
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 1, 0);
            chk("s2_no_preempt", 64'(obs_grant), 64'd1);
        end
        chk("s2_acks0_total", 64'(acks0), 64'd20);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        chk("s2_release_idle", 64'(obs_grant), 64'd0);
        step(0, 1, 1, 0);
        chk("s2_release_grant", 64'(obs_grant), 64'd2);
`endif
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // simultaneous requests from idle with last owner = port 0
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
`ifdef WSHB_ARB_RR_EN
        chk("tie_grant", 64'(obs_grant), 64'd2);
`else
        chk("tie_grant", 64'(obs_grant), 64'd1);
`endif
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // owner 1 drops cyc on the preempting ack: release wins
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        #1;
        chk("drop_vs_preempt_state", 64'(dut.state), 64'(IDLE));
        step(1, 0, 0, 0);
        chk("drop_idle_grant", 64'(obs_grant), 64'd0);
        step(1, 0, 0, 0);
        chk("drop_next_grant", 64'(obs_grant), 64'd1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // reset while port 1 owns with an ack on the bus
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("rst_pre_grant", 64'(obs_grant), 64'd2);
        step(0, 1, 1, 1);
        #1;
        chk("rst_mid_grant", 64'(grant), 64'd0);
        chk("rst_mid_fwd", 64'({ifm.cyc, ifm.stb}), 64'd0);
        chk("rst_mid_ack_cnt", 64'(dut.ack_cnt), 64'd0);
        chk("rst_mid_ack1", 64'(if1.ack), 64'd0);
        step(0, 1, 1, 0);

        // randomized traffic with occasional resets
        rc0 = 0; rc1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) rc0 = ~rc0;
            if ($urandom_range(7) == 0) rc1 = ~rc1;
            step(rc0, rc1, 1'($urandom_range(1)), ($urandom_range(199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wshb_arbiter.md
# wshb_arbiter

Two-master, one-slave Wishbone arbiter sharing the single SDRAM Wishbone port between the VGA framebuffer reader (port 0) and a second master such as a pattern or host frame writer (port 1). It holds the grant for a whole bus cycle and forwards the owner's signals to the slave. It preempts an owner that keeps `cyc` high indefinitely; the VGA reader does this while its FIFO is not full. Without preemption, a writer could never reach SDRAM during display.

## Interface
- `MAX_ACKS`, default 64: acks an owner may collect while the other master waits before it is preempted; legal range ≥1.
- `clk` input 1: Wishbone clock, the only clock in the block.
- `rst` input 1: reset, synchronous, active-high.
- `wshb_ifs0` `wshb_if.slave`: requester 0 (VGA reader).
- `wshb_ifs1` `wshb_if.slave`: requester 1 (writer).
- `wshb_ifm` `wshb_if.master`: to the SDRAM controller.
- `grant` output 2: one-hot current owner; `00` = none; for debug and the testbench.

## Operation
- State machine (registered), with states IDLE, OWN0, OWN1 and SWITCH.
  - IDLE:
    - only `cyc0` → OWN0; only `cyc1` → OWN1.
    - both → tie-break (see Configuration).
  - OWNx:
    - `cycx`=0 → IDLE.
    - else if forwarded `ack`=1 and `cyc` of other =1 and `ack_cnt`==MAX_ACKS-1 → SWITCH.
    - else stay.
  - SWITCH, one dead cycle with nothing forwarded:
    - → OWN(other) if other `cyc`=1, else IDLE.
- Forwarding (combinational from the registered owner):
  - `cyc`, `stb`, `adr`, `we`, `sel`, `cti`, `bte`, `dat_ms` come from the owner.
  - With no owner (IDLE/SWITCH), every forwarded field is 0.
- Return path:
  - `ack` is routed to the owner only; the non-owner sees `ack`=0.
  - `dat_sm` is broadcast to both ports.
- `ack_cnt`:
  - Cleared on entry to OWN0 or OWN1.
  - Increments on each forwarded `ack` and saturates at MAX_ACKS-1.
  - Width is `$clog2(MAX_ACKS)` with a minimum of 1.
  - It counts only while the other master requests; while the other `cyc` is 0 it holds 0.
- A preempted master keeps `cyc`/`stb` high and simply sees no ack until re-granted. This is legal for classic cycles (`cti`=0).
- `last` register holds the last owner, updated on each entry to OWN0/OWN1.

## Timing
- Reset values:
  - state IDLE, `last`=1, `ack_cnt`=0, `grant`=00.
  - all forwarded outputs 0; both returned acks 0.
- Grant latency: `cyc` rising in IDLE at edge n → owner registered at n+1 → forwarded `cyc`/`stb` visible after edge n+1. That is one cycle of latency.
- Release: owner drops `cyc` at cycle k → IDLE at k+1.
  - If the other master is requesting, it is granted at k+2.
- Preemption: the MAX_ACKS-th ack, counted since the other master began waiting, completes normally. The owner is masked from the next cycle. The other master is forwarded two cycles after that ack.
- Simultaneous drop of owner `cyc` and preemption condition → IDLE (release wins).
- `rst` asserted mid-transfer → the next edge forces IDLE with all outputs 0. Any in-flight slave ack is discarded.
- No combinational path from the ack input to any `cyc`/`stb` output.

## Configuration
- `WSHB_ARB_RR_EN` defined:
  - IDLE tie-break grants the port ≠ `last` (round-robin).
  - Preemption applies to both ports.
- Not defined:
  - Fixed priority: port 0 wins ties.
  - Preemption applies only to port 1 (the writer). The VGA reader is never preempted, but the writer still gets the bus whenever the reader drops `cyc` (FIFO full).

## Structure
- Package `wshb_arb_pkg`: `arb_state_t` enum (IDLE, OWN0, OWN1, SWITCH) and `owner_t`.
- No sub-module: the FSM, counter and mux fit in one module.

## Test plan
- Reset, then only `cyc0`=1 with slave acking every cycle → `grant`=01 one cycle later; 10 reads reach port 0; port 1 sees `ack`=0.
- Port 0 holds `cyc`; port 1 raises `cyc` at ack 5; MAX_ACKS=4 with `WSHB_ARB_RR_EN` defined → port 0 is masked after its 4th ack from then; one dead cycle; `grant`=10; port 1 gets its ack at the configured position.
- Same stimulus without the macro → port 0 is never preempted. Port 0 drops `cyc` after 20 acks → IDLE, then `grant`=10 the next cycle.
- Both raise `cyc` in the same cycle from IDLE, `last`=0, macro defined → `grant`=10. Without the macro → `grant`=01.
- Owner drops `cyc` in the same cycle as the preempting ack → IDLE, then grant to the other port; no SWITCH state.
- `rst` pulsed while OWN1 with the slave ack pending → next cycle `grant`=00, forwarded `cyc`/`stb`=0, `ack_cnt`=0.
